// File: rtl/otter_intr_ctrl.sv
// Interrupt controller: per-source sync/debounce/edge-detect into pending bits,
// masked fixed-priority arbitration, and a request/ack handshake to the CPU.
module otter_intr_ctrl #(
    parameter int NUM_SRC   = 4,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8,
    parameter int ID_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wd,
    input  logic               intr_ack,
    output logic               intr,
    output logic [ID_W-1:0]    intr_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [NUM_SRC-1:0]            sync1_q, sync1_d;
    logic [NUM_SRC-1:0]            sync2_q, sync2_d;
    logic [NUM_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_SRC-1:0]            db_q, db_d;
    logic [NUM_SRC-1:0]            pend_q, pend_d;
    logic [NUM_SRC-1:0]            mask_q, mask_d;
    state_t                        state_q, state_d;
    logic [ID_W-1:0]               id_q, id_d;

    logic [NUM_SRC-1:0]            db_rise;
    logic [NUM_SRC-1:0]            eligible;
    logic [NUM_SRC-1:0]            ack_clr;
    logic [ID_W-1:0]               winner;

    // Two-flop synchroniser followed by a run-length debouncer per source
    always_comb begin
        sync1_d = src_in;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        db_rise = db_d & ~db_q;
    end

    // Lowest index wins: scan downward so the last hit is the smallest index
    always_comb begin
        eligible = pend_q & mask_q;
        winner   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ack_clr = '0;
        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    state_d = S_REQ;
                    id_d    = winner;
                end
            end
            S_REQ: begin
                if (intr_ack) begin
                    state_d = S_HOLD;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (ID_W'(i) == id_q) ack_clr[i] = 1'b1;
                    end
                end
            end
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        intr = (state_q == S_REQ);
    end

    // A new rise on the same edge as an ack keeps the bit set
    always_comb begin
        pend_d = (pend_q & ~ack_clr) | db_rise;
        mask_d = mask_we ? mask_wd : mask_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            db_q    <= '0;
            pend_q  <= '0;
            mask_q  <= '1;
            state_q <= S_IDLE;
            id_q    <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    assign intr_id = id_q;
    assign pending = pend_q;
    assign mask    = mask_q;

endmodule
